// File: rtl/ps2_pkg.sv
// Shared types and scancode constants for the PS/2 keyboard front end.
package ps2_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;

    localparam logic [7:0] ASC_UP    = 8'h80;
    localparam logic [7:0] ASC_DOWN  = 8'h81;
    localparam logic [7:0] ASC_LEFT  = 8'h82;
    localparam logic [7:0] ASC_RIGHT = 8'h83;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: pin synchronizers, falling-edge detect,
// frame FSM with odd-parity/stop check and an inter-edge timeout.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT = 25000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [2:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          fall;
    logic          bit_in;

    rx_state_t     state, state_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          par, par_n;
    logic [TW-1:0] timer, timer_n;
    logic          valid_n;
    logic [7:0]    data_n;

    // Synchronizers idle high so reset never fabricates an edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync  <= 3'b111;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    assign fall   = clk_sync[2] & ~clk_sync[1];
    assign bit_in = data_sync[1];

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= RX_IDLE;
            bit_cnt    <= 3'd0;
            shreg      <= 8'h00;
            par        <= 1'b0;
            timer      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            par        <= par_n;
            timer      <= timer_n;
            byte_valid <= valid_n;
            byte_data  <= data_n;
        end
    end

    // An edge always wins over a simultaneous timeout.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        par_n     = par;
        timer_n   = timer;
        valid_n   = 1'b0;
        data_n    = byte_data;
        if (fall) begin
            timer_n = '0;
            case (state)
                RX_IDLE: begin
                    if (!bit_in) begin
                        state_n   = RX_DATA;
                        bit_cnt_n = 3'd0;
                    end
                end
                RX_DATA: begin
                    shreg_n   = {bit_in, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n = RX_PARITY;
                    end
                end
                RX_PARITY: begin
                    par_n   = bit_in;
                    state_n = RX_STOP;
                end
                RX_STOP: begin
                    if (bit_in && (^{shreg, par})) begin
                        valid_n = 1'b1;
                        data_n  = shreg;
                    end
                    state_n = RX_IDLE;
                end
                default: state_n = RX_IDLE;
            endcase
        end else if (state != RX_IDLE) begin
            if (timer == TW'(TIMEOUT - 1)) begin
                state_n   = RX_IDLE;
                bit_cnt_n = 3'd0;
                timer_n   = '0;
            end else begin
                timer_n = timer + TW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard front end: prefix/shift/caps tracking and scancode set 2
// to ASCII translation, strobing kdone once per translated key press.
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT = 25000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       kdone,
    output logic [7:0] ascii
);

    logic       byte_valid;
    logic [7:0] byte_data;

    logic       brk, brk_n;
    logic       ext, ext_n;
    logic       shift, shift_n;
    logic       caps, caps_n;
    logic       kdone_n;
    logic [7:0] ascii_n;

    logic       hit_c;
    logic       letter;
    logic       digit;
    logic [7:0] base;
    logic [7:0] alt;
    logic [7:0] code_c;

    ps2_rx #(
        .TIMEOUT (TIMEOUT)
    ) u_rx (
        .clock      (clock),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (byte_valid),
        .byte_data  (byte_data)
    );

    // Scancode set 2 lookup; base is the unshifted character, alt the shifted symbol.
    always_comb begin
        hit_c  = 1'b1;
        letter = 1'b0;
        digit  = 1'b0;
        base   = 8'h00;
        alt    = 8'h00;
        if (ext) begin
            case (byte_data)
                SC_UP:    base = ASC_UP;
                SC_DOWN:  base = ASC_DOWN;
                SC_LEFT:  base = ASC_LEFT;
                SC_RIGHT: base = ASC_RIGHT;
                default:  hit_c = 1'b0;
            endcase
        end else begin
            case (byte_data)
                8'h1C: begin letter = 1'b1; base = 8'h61; end
                8'h32: begin letter = 1'b1; base = 8'h62; end
                8'h21: begin letter = 1'b1; base = 8'h63; end
                8'h23: begin letter = 1'b1; base = 8'h64; end
                8'h24: begin letter = 1'b1; base = 8'h65; end
                8'h2B: begin letter = 1'b1; base = 8'h66; end
                8'h34: begin letter = 1'b1; base = 8'h67; end
                8'h33: begin letter = 1'b1; base = 8'h68; end
                8'h43: begin letter = 1'b1; base = 8'h69; end
                8'h3B: begin letter = 1'b1; base = 8'h6A; end
                8'h42: begin letter = 1'b1; base = 8'h6B; end
                8'h4B: begin letter = 1'b1; base = 8'h6C; end
                8'h3A: begin letter = 1'b1; base = 8'h6D; end
                8'h31: begin letter = 1'b1; base = 8'h6E; end
                8'h44: begin letter = 1'b1; base = 8'h6F; end
                8'h4D: begin letter = 1'b1; base = 8'h70; end
                8'h15: begin letter = 1'b1; base = 8'h71; end
                8'h2D: begin letter = 1'b1; base = 8'h72; end
                8'h1B: begin letter = 1'b1; base = 8'h73; end
                8'h2C: begin letter = 1'b1; base = 8'h74; end
                8'h3C: begin letter = 1'b1; base = 8'h75; end
                8'h2A: begin letter = 1'b1; base = 8'h76; end
                8'h1D: begin letter = 1'b1; base = 8'h77; end
                8'h22: begin letter = 1'b1; base = 8'h78; end
                8'h35: begin letter = 1'b1; base = 8'h79; end
                8'h1A: begin letter = 1'b1; base = 8'h7A; end
                8'h45: begin digit = 1'b1; base = 8'h30; alt = 8'h29; end
                8'h16: begin digit = 1'b1; base = 8'h31; alt = 8'h21; end
                8'h1E: begin digit = 1'b1; base = 8'h32; alt = 8'h40; end
                8'h26: begin digit = 1'b1; base = 8'h33; alt = 8'h23; end
                8'h25: begin digit = 1'b1; base = 8'h34; alt = 8'h24; end
                8'h2E: begin digit = 1'b1; base = 8'h35; alt = 8'h25; end
                8'h36: begin digit = 1'b1; base = 8'h36; alt = 8'h5E; end
                8'h3D: begin digit = 1'b1; base = 8'h37; alt = 8'h26; end
                8'h3E: begin digit = 1'b1; base = 8'h38; alt = 8'h2A; end
                8'h46: begin digit = 1'b1; base = 8'h39; alt = 8'h28; end
                8'h29: base = 8'h20;
                8'h5A: base = 8'h0D;
                8'h66: base = 8'h08;
                8'h0D: base = 8'h09;
                8'h76: base = 8'h1B;
                default: hit_c = 1'b0;
            endcase
        end
        if (letter) begin
            code_c = (shift ^ caps) ? (base - 8'h20) : base;
        end else if (digit) begin
            code_c = shift ? alt : base;
        end else begin
            code_c = base;
        end
    end

    // Prefix bytes only set flags; any other byte consumes and clears them.
    always_comb begin
        brk_n   = brk;
        ext_n   = ext;
        shift_n = shift;
        caps_n  = caps;
        kdone_n = 1'b0;
        ascii_n = ascii;
        if (byte_valid) begin
            if (byte_data == SC_EXT) begin
                ext_n = 1'b1;
            end else if (byte_data == SC_BRK) begin
                brk_n = 1'b1;
            end else begin
                brk_n = 1'b0;
                ext_n = 1'b0;
                if (!ext && (byte_data == SC_LSHIFT || byte_data == SC_RSHIFT)) begin
                    shift_n = ~brk;
                end else if (byte_data == SC_CAPS) begin
                    if (!brk) begin
                        caps_n = ~caps;
                    end
                end else if (!brk && hit_c) begin
                    kdone_n = 1'b1;
                    ascii_n = code_c;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            brk   <= 1'b0;
            ext   <= 1'b0;
            shift <= 1'b0;
            caps  <= 1'b0;
            kdone <= 1'b0;
            ascii <= 8'h00;
        end else begin
            brk   <= brk_n;
            ext   <= ext_n;
            shift <= shift_n;
            caps  <= caps_n;
            kdone <= kdone_n;
            ascii <= ascii_n;
        end
    end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: a table of PS/2 frames with expected
// strobe counts and held ascii, plus timeout and mid-frame reset sequences.
module tb_ps2_keyboard;

    localparam int HALF = 20;
    localparam int GAP  = 20;

    typedef struct {
        logic [7:0] code;
        bit         bad;
        int         n;
        logic [7:0] asc;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       kdone;
    logic [7:0] ascii;

    int   errors = 0;
    int   checks = 0;
    int   strobes = 0;
    int   last_lat = 0;
    int   n0;
    vec_t vecs[$];

    ps2_keyboard #(.TIMEOUT(25000)) dut (
        .clock    (clock),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .kdone    (kdone),
        .ascii    (ascii)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (kdone) strobes++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] code, input bit bad, input int n, input logic [7:0] asc);
        vec_t v;
        v.code = code; v.bad = bad; v.n = n; v.asc = asc;
        vecs.push_back(v);
    endtask

    // Drives the first nbits of an 11-bit frame; records kdone latency after the last fall.
    task automatic send_frame(input logic [7:0] b, input bit bad, input int nbits);
        logic [10:0] f;
        logic        par;
        par = (~(^b)) ^ bad;
        f = {1'b1, par, b, 1'b0};
        last_lat = 0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clock);
            ps2_data = f[i];
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b0;
            for (int k = 1; k <= HALF; k++) begin
                @(negedge clock);
                if (kdone && last_lat == 0) last_lat = k;
            end
            ps2_clk = 1'b1;
        end
        repeat (GAP) @(negedge clock);
        ps2_data = 1'b1;
    endtask

    initial begin
        add(8'h1C, 0, 1, 8'h61);
        add(8'h12, 0, 0, 8'h61);
        add(8'h1C, 0, 1, 8'h41);
        add(8'hF0, 0, 0, 8'h41);
        add(8'h12, 0, 0, 8'h41);
        add(8'h1C, 0, 1, 8'h61);
        add(8'hF0, 0, 0, 8'h61);
        add(8'h1C, 0, 0, 8'h61);
        add(8'h58, 0, 0, 8'h61);
        add(8'h1C, 0, 1, 8'h41);
        add(8'h12, 0, 0, 8'h41);
        add(8'h1C, 0, 1, 8'h61);
        add(8'h16, 0, 1, 8'h21);
        add(8'hF0, 0, 0, 8'h21);
        add(8'h12, 0, 0, 8'h21);
        add(8'h16, 0, 1, 8'h31);
        add(8'h5A, 0, 1, 8'h0D);
        add(8'h1C, 1, 0, 8'h0D);
        add(8'h16, 0, 1, 8'h31);
        add(8'h58, 0, 0, 8'h31);
        add(8'hF0, 0, 0, 8'h31);
        add(8'h58, 0, 0, 8'h31);
        add(8'h1C, 0, 1, 8'h61);
        add(8'hE0, 0, 0, 8'h61);
        add(8'h75, 0, 1, 8'h80);
        add(8'hE0, 0, 0, 8'h80);
        add(8'hF0, 0, 0, 8'h80);
        add(8'h75, 0, 0, 8'h80);
        add(8'h75, 0, 0, 8'h80);
        add(8'hE0, 0, 0, 8'h80);
        add(8'h6B, 0, 1, 8'h82);
        add(8'hE0, 0, 0, 8'h82);
        add(8'h72, 0, 1, 8'h81);
        add(8'hE0, 0, 0, 8'h81);
        add(8'h74, 0, 1, 8'h83);
        add(8'h66, 0, 1, 8'h08);
        add(8'h0D, 0, 1, 8'h09);
        add(8'h76, 0, 1, 8'h1B);
        add(8'h29, 0, 1, 8'h20);
        add(8'h45, 0, 1, 8'h30);
        add(8'hE0, 0, 0, 8'h30);
        add(8'h1C, 0, 0, 8'h30);
        add(8'h1C, 0, 1, 8'h61);
        add(8'h59, 0, 0, 8'h61);
        add(8'h3E, 0, 1, 8'h2A);
        add(8'hF0, 0, 0, 8'h2A);
        add(8'h59, 0, 0, 8'h2A);
        add(8'h3E, 0, 1, 8'h38);
        add(8'hE0, 0, 0, 8'h38);
        add(8'h12, 0, 0, 8'h38);
        add(8'h1C, 0, 1, 8'h61);
        add(8'h4D, 0, 1, 8'h70);

        repeat (4) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("reset kdone", 32'(kdone), 32'd0);
        check("reset ascii", 32'(ascii), 32'h00);

        foreach (vecs[i]) begin
            n0 = strobes;
            send_frame(vecs[i].code, vecs[i].bad, 11);
            check($sformatf("vec%0d code %0h strobes", i, vecs[i].code), 32'(strobes - n0), 32'(vecs[i].n));
            check($sformatf("vec%0d code %0h ascii", i, vecs[i].code), 32'(ascii), 32'(vecs[i].asc));
            if (vecs[i].n == 1)
                check($sformatf("vec%0d latency", i), 32'(last_lat), 32'd4);
        end

        // Partial frame abandoned by the inter-edge timeout.
        send_frame(8'h1C, 0, 5);
        repeat (25100) @(negedge clock);
        n0 = strobes;
        send_frame(8'h29, 0, 11);
        check("timeout strobes", 32'(strobes - n0), 32'd1);
        check("timeout ascii", 32'(ascii), 32'h20);

        // Partial frame discarded by reset.
        send_frame(8'h1C, 0, 5);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("midreset ascii", 32'(ascii), 32'h00);
        check("midreset kdone", 32'(kdone), 32'd0);
        n0 = strobes;
        send_frame(8'h29, 0, 11);
        check("midreset strobes", 32'(strobes - n0), 32'd1);
        check("midreset frame ascii", 32'(ascii), 32'h20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard.md
# ps2_keyboard

PS/2 keyboard front end that drives the port block's keyboard inputs: it deserializes device-to-host PS/2 frames, tracks make/break/extended prefixes and Shift state, and translates scancode set 2 into ASCII. Each translated key press produces a one-cycle `kdone` strobe with the code on `ascii`, wired straight to the port block's `p_kdone`/`p_ascii`. Host-to-device commands (LEDs, reset) are out of scope.

## Interface
- `TIMEOUT`, 25000: clock cycles without a `ps2_clk` falling edge before a partial frame is discarded (1 ms at 25 MHz).
- `clock` in 1: system clock, 25 MHz; the only clock.
- `reset` in 1: synchronous, active-high reset.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous.
- `kdone` out 1: one-cycle strobe; a translated key press is on `ascii`.
- `ascii` out 8: last translated code; held until the next strobe.

## Operation
- Both pins pass through 2-FF synchronizers. A third register on `ps2_clk` gives the falling-edge detect. All frame logic acts only on detected falling edges, sampling synced `ps2_data`.
- Frame: start bit 0, 8 data bits LSB first, odd parity, stop bit 1.
- Receiver states:
  - IDLE: a sampled 0 starts the frame and moves to DATA; a sampled 1 is ignored.
  - DATA: 8 edges shift in the data bits, then move to PARITY.
  - PARITY: latch the parity bit.
  - STOP: accept the byte only if stop = 1 and the ones count over data+parity is odd. Either way, return to IDLE.
- Rejected frames are dropped silently and do not change the decoder flags.
- Timeout counter: cleared on every falling edge. It counts only when the receiver is not in IDLE. Reaching `TIMEOUT` forces IDLE and clears the bit count.
- Decoder, on each accepted byte:
  - E0 sets `ext`.
  - F0 sets `brk`.
  - Any other byte is a key code. It is processed, then `brk` and `ext` are both cleared.
- Shift: 12h and 59h with `ext`=0. Make sets `shift`, break clears it. No strobe.
- Caps Lock: 58h make toggles `caps`. Break is ignored. No strobe.
- Break of any other key: no strobe.
- Make translation, strobed:
  - Letters: 'a'..'z' (61h..7Ah). Upper case when `shift` XOR `caps`.
  - Digit row 0..9: 30h..39h unshifted; US-layout symbols when shifted.
  - 29h→20h, 5Ah→0Dh, 66h→08h, 0Dh→09h, 76h→1Bh.
  - With `ext`=1: 75h→80h (up), 72h→81h (down), 6Bh→82h (left), 74h→83h (right).
  - All other codes, extended or not: no strobe.
- Reset values:
  - Outputs: `kdone`=0, `ascii`=00h.
  - Internal: receiver in IDLE; `brk`, `ext`, `shift`, `caps` all 0; timeout counter 0.
- Reset mid-frame discards the frame. The first complete frame after reset decodes normally.

## Timing
- Pin to edge-detect latency: 3 clocks.
- `kdone` rises on the clock after the stop-bit falling edge is detected. At that same clock `ascii` changes to the new code.
- `kdone` is high for exactly 1 clock.
- Back-to-back frames are at least about 1 ms apart, so strobes never overlap. No backpressure exists; the consumer must latch on `kdone`.
- Timeout firing and a falling edge in the same cycle: the edge wins and the counter clears.
- `reset` overrides all other activity in the same cycle.

## Structure
- Shared package `ps2_pkg`:
  - Receiver state enum.
  - Prefix constants E0h and F0h.
  - Shift, Caps and extended arrow codes.
  - Arrow ASCII codes 80h..83h.
- Sub-module `ps2_rx`: synchronizers, edge detect, frame FSM, parity and timeout. It outputs `byte_valid` (1 clock) and `byte_data[7:0]`.
- The top level holds the prefix/shift decoder and the combinational scancode-to-ASCII case table.

## Test plan
- Frame 1Ch (parity 0, correct) → one `kdone`, `ascii`=61h, 4 clocks after the stop edge.
- 12h, then 1Ch, then F0h 12h, then 1Ch → exactly two strobes: `ascii`=41h, then `ascii`=61h.
- F0h 1Ch, and separately 58h then 1Ch → no strobe for the break; `ascii`=41h after the Caps toggle.
- 1Ch with a wrong parity bit, then a correct 16h → no strobe for the bad frame, then `ascii`=31h.
- 5 bits of a frame, then 25000 idle clocks, then a full 29h frame → single strobe, `ascii`=20h. Repeat with `reset` asserted mid-frame in place of the idle gap: same single strobe.
- E0h 75h, then E0h F0h 75h → one strobe `ascii`=80h, no strobe for the release, `ext` cleared afterwards.
